// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register: transmit end of the serial link.
// Words are accepted over a load/ready handshake and sent one bit per enabled clock.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             shift_en,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             last_s;

    // Shift one position toward the output end, zero fill behind.
    always_comb begin
        shreg_d = shreg_q;
        if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Serial outputs come only from registered state; ready also sees the
    // end-of-word edge so back-to-back words need no idle cycle.
    always_comb begin
        last_s     = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        sout_valid = (state_q == SHIFT);
        if (state_q == SHIFT) begin
            sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end else begin
            sout = 1'b0;
        end
        ready = !rst && ((state_q == IDLE) || (last_s && shift_en));
        last  = last_s;
        done  = done_q;
    end

    // Handshake / shift state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shreg_q <= din;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (last_s) begin
                            done_q <= 1'b1;
                            if (load) begin
                                shreg_q <= din;
                                cnt_q   <= '0;
                            end else begin
                                shreg_q <= '0;
                                cnt_q   <= '0;
                                state_q <= IDLE;
                            end
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (4-bit MSB-first,
// 4-bit LSB-first, 8-bit MSB-first) driven one at a time by directed words.
module tb_piso_serializer;

    typedef struct packed {
        logic [1:0] inst;
        logic       b;
        logic       l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] load_s;
    logic [2:0] se_s;
    logic [3:0] din_m;
    logic [3:0] din_l;
    logic [7:0] din_w;
    logic [2:0] rdy_s, sout_s, vld_s, last_s, done_s;

    exp_t       sb[$];
    int         tests_run = 0;
    int         fails     = 0;
    logic [2:0] pend = 3'b000;
    logic [3:0] sipo = 4'b0000;
    int         cyc = 0;
    int         last_done = 0;
    int         prev_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .rst(rst), .din(din_m), .load(load_s[0]), .shift_en(se_s[0]),
        .ready(rdy_s[0]), .sout(sout_s[0]), .sout_valid(vld_s[0]),
        .last(last_s[0]), .done(done_s[0]));

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .rst(rst), .din(din_l), .load(load_s[1]), .shift_en(se_s[1]),
        .ready(rdy_s[1]), .sout(sout_s[1]), .sout_valid(vld_s[1]),
        .last(last_s[1]), .done(done_s[1]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w (
        .clk(clk), .rst(rst), .din(din_w), .load(load_s[2]), .shift_en(se_s[2]),
        .ready(rdy_s[2]), .sout(sout_s[2]), .sout_valid(vld_s[2]),
        .last(last_s[2]), .done(done_s[2]));

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every valid bit is compared with the queue head; it is popped
    // only when shift_en moves it on, otherwise it must hold.
    always @(negedge clk) begin
        if (rst) begin
            pend = 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("done%0d", k), {7'd0, done_s[k]}, {7'd0, pend[k]});
                if (k == 0 && done_s[0]) begin
                    prev_done = last_done;
                    last_done = cyc;
                end
                pend[k] = 1'b0;
                if (vld_s[k]) begin
                    if (sb.size() == 0 || sb[0].inst != 2'(k)) begin
                        tests_run++;
                        fails++;
                        $display("FAIL unexpected_bit%0d: actual sout_valid=1 required no bit (t=%0t)", k, $time);
                    end else begin
                        check($sformatf("sout%0d", k), {7'd0, sout_s[k]}, {7'd0, sb[0].b});
                        check($sformatf("last%0d", k), {7'd0, last_s[k]}, {7'd0, sb[0].l});
                        if (se_s[k]) begin
                            pend[k] = sb[0].l;
                            if (k == 0) sipo = {sipo[2:0], sout_s[0]};
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        int  w   = (k == 2) ? 8 : 4;
        int  t   = 0;
        for (int i = 0; i < w; i++) begin
            int   idx = (k == 1) ? i : (w - 1 - i);
            exp_t e;
            e.inst = 2'(k);
            e.b    = d[idx];
            e.l    = (i == w - 1);
            sb.push_back(e);
        end
        case (k)
            0:       din_m = d[3:0];
            1:       din_l = d[3:0];
            default: din_w = d;
        endcase
        load_s[k] = 1'b1;
        @(negedge clk);
        while (!rdy_s[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_s[k]) begin
            tests_run++;
            fails++;
            $display("FAIL ready_timeout%0d: actual ready=0 required 1", k);
        end
        @(posedge clk);
        #1;
        load_s[k] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            tests_run++;
            fails++;
            $display("FAIL drain_timeout: actual %0d bits pending required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_s = 3'b000; se_s = 3'b111;
        din_m = 4'd0; din_l = 4'd0; din_w = 8'd0;
        #2;
        check("rst_ready", {5'd0, rdy_s}, 8'd0);
        check("rst_valid", {5'd0, vld_s}, 8'd0);
        check("rst_sout",  {5'd0, sout_s}, 8'd0);
        check("rst_done",  {5'd0, done_s}, 8'd0);
        #10 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {5'd0, rdy_s}, 8'd7);
        @(posedge clk); #1;

        // Basic MSB-first, looped into a bench SIPO.
        send(0, 8'h0B);
        drain();
        check("basic_ready", {7'd0, rdy_s[0]}, 8'd1);
        check("sipo_q", {4'd0, sipo}, 8'h0B);

        // Back-to-back words, load held until accepted at the end-of-word edge.
        send(0, 8'h0B);
        send(0, 8'h06);
        drain();
        check("b2b_done_gap", 8'(last_done - prev_done), 8'd4);

        // Stall after the 2nd bit for 3 edges, then 2 edges on the last bit.
        send(0, 8'h09);
        @(posedge clk); #1 se_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 se_s[0] = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 se_s[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_last", {7'd0, last_s[0]}, 8'd1);
            check("stall_ready", {7'd0, rdy_s[0]}, 8'd0);
            @(posedge clk);
        end
        #1 se_s[0] = 1'b1;
        drain();

        // Load pulse while busy must be ignored.
        send(0, 8'h0F);
        @(posedge clk); #1;
        din_m = 4'b0000; load_s[0] = 1'b1;
        @(posedge clk); #1 load_s[0] = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        @(posedge clk); #1;

        // Asynchronous reset mid-word.
        send(0, 8'h0A);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("arst_sout",  {7'd0, sout_s[0]}, 8'd0);
        check("arst_valid", {7'd0, vld_s[0]},  8'd0);
        check("arst_last",  {7'd0, last_s[0]}, 8'd0);
        check("arst_done",  {7'd0, done_s[0]}, 8'd0);
        check("arst_ready", {7'd0, rdy_s[0]},  8'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("arst_ready_after", {7'd0, rdy_s[0]}, 8'd1);
        @(posedge clk); #1;
        send(0, 8'h05);
        drain();

        // LSB-first 4-bit, then 8-bit MSB-first.
        send(1, 8'h0C);
        drain();
        send(2, 8'hA5);
        drain();
        check("final_ready", {5'd0, rdy_s}, 8'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out shift register: the transmit end of the team's 4-bit SIPO serial link.
- Accepts a WIDTH-bit word over a load/ready handshake and shifts it out one bit per enabled clock on sout.
- Flags each valid bit and the last bit of every word, and pulses done at word completion.
- Supports back-to-back words with no idle gap, so a downstream SIPO can rebuild the words directly.

Parameters:
WIDTH, 4, word length in bits (>=2)
MSB_FIRST, 1, 1 = din[WIDTH-1] transmitted first; 0 = din[0] first

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word, sampled only on an accepted load
load  input  1  word-valid request from the producer
shift_en  input  1  shift enable; low stalls the shift without losing state
ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid data bit
last  output  1  current sout bit is the final bit of the word
done  output  1  one-cycle pulse after the final bit of a word completes

Behaviour:
- Reset (async, immediate on rst rise, independent of clk):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, last=0, done=0.
  - ready=0 while rst is high; ready=1 from the first cycle after rst falls.
- State machine:
  - IDLE: ready=1, sout_valid=0, sout=0. load=1 at a rising edge captures din, sets cnt=0 and moves to SHIFT. shift_en is don't-care for acceptance.
  - SHIFT: sout_valid=1. sout = shreg[WIDTH-1] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0).
  - SHIFT, shift_en=1 at an edge: shreg shifts one position toward the output end (zero fill), cnt increments.
  - SHIFT, shift_en=0: shreg, cnt, sout, sout_valid and last all hold.
  - last = (state==SHIFT) && (cnt==WIDTH-1).
  - ready = !rst && (state==IDLE || (last && shift_en)).
- End of word (edge with last=1 and shift_en=1):
  - done=1 for exactly the following cycle.
  - If load=1: new din captured, cnt=0, stay in SHIFT. The first bit of the new word appears in the next cycle with no gap.
  - Else: go to IDLE.
- Latency: a load accepted at edge N puts bit 0 on sout during cycle N..N+1. A word takes exactly WIDTH enabled cycles.
- A load while ready=0 is ignored. din is not sampled and no error is flagged. The producer holds load until it sees ready.
- A stall on the last bit holds last=1, keeps ready=0 and defers done.
- Reset mid-word: the word is discarded and no done pulse is produced. After reset the block is in IDLE and accepts a new load normally.
- rst asserted together with load: reset wins and the word is not captured.
- done is registered, never combinational. sout, sout_valid and last are driven from registered state only.

Test Plan:
- Basic MSB-first:
  - Stimulus: WIDTH=4, period 10, rst high 10 then low; load=1 with din=4'b1011 for one cycle; shift_en=1.
  - Required: sout=1,0,1,1 on 4 consecutive cycles; sout_valid high 4 cycles; last only on the 4th bit; done on the next cycle; ready back to 1.
  - Looped into a SIPO, Q must read 1011.
- Back-to-back:
  - Stimulus: din=1011 then 0110, load held high through the last bit of the first word.
  - Required: 8 contiguous valid bits 1,0,1,1,0,1,1,0; sout_valid never drops; two done pulses 4 cycles apart.
- Stall:
  - Stimulus: din=1001; shift_en low for 3 cycles after the 2nd bit, and low again for 2 cycles on the last bit.
  - Required: the 2nd bit (0) holds for 4 cycles; last holds with ready=0; done only after shift_en returns; serial stream still 1,0,0,1.
- LSB-first:
  - Stimulus: MSB_FIRST=0, din=4'b1100.
  - Required: sout=0,0,1,1.
  - Then WIDTH=8, din=8'hA5, MSB_FIRST=1: sout=1,0,1,0,0,1,0,1 with last on the 8th bit.
- Ignored load:
  - Stimulus: pulse load with din=0000 during bit 2 of word 1111.
  - Required: stream 1,1,1,1 unaffected; no second word.
- Async reset mid-word:
  - Stimulus: din=1010; assert rst between clock edges after the 2nd bit.
  - Required: sout, sout_valid, last and done go to 0 immediately, without waiting for a clock edge; ready=0 during reset; no done pulse.
  - After release: a load of din=0101 shifts out 0,1,0,1 normally.
